// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a direct-mapped BTB and registered mispredict redirect.
// Define BP_TAG_EN to store and compare per-entry tags; otherwise aliasing PCs share an entry.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         cnt_q [ENTRIES];
    logic [1:0]         cnt_d [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        tgt_d [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic                  f_hit, r_hit;

    assign f_idx = fetch_pc[INDEX_BITS+1:2];
    assign r_idx = res_pc[INDEX_BITS+1:2];

`ifdef BP_TAG_EN
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_d [ENTRIES];
    logic [TAG_BITS-1:0] f_tag, r_tag;

    assign f_tag = fetch_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign r_tag = res_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
`else
    assign f_hit = valid_q[f_idx];
    assign r_hit = valid_q[r_idx];
`endif

    // Table training; lookup reads *_q so same-index lookups see old contents.
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
`ifdef BP_TAG_EN
        tag_d   = tag_q;
`endif
        if (res_valid) begin
            if (r_hit) begin
                if (res_taken) begin
                    if (cnt_q[r_idx] != 2'b11)
                        cnt_d[r_idx] = cnt_q[r_idx] + 2'b01;
                    tgt_d[r_idx] = res_target;
                end else if (cnt_q[r_idx] != 2'b00) begin
                    cnt_d[r_idx] = cnt_q[r_idx] - 2'b01;
                end
            end else if (res_taken) begin
                valid_d[r_idx] = 1'b1;
                cnt_d[r_idx]   = 2'b10;
                tgt_d[r_idx]   = res_target;
`ifdef BP_TAG_EN
                tag_d[r_idx]   = r_tag;
`endif
            end
        end
    end

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;
    logic        lk_taken;
    logic        mispredict;

    always_comb begin
        lk_taken      = f_hit & cnt_q[f_idx][1];
        pred_valid_d  = fetch_valid & ~redirect_valid_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (pred_valid_d) begin
            pred_taken_d  = lk_taken;
            pred_target_d = lk_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;
        end
    end

    always_comb begin
        mispredict = res_valid &
                     ((res_taken != res_pred_taken) |
                      (res_taken & (res_target != res_pred_target)));
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        mis_cnt_d        = mis_cnt_q;
        if (mispredict) begin
            redirect_pc_d = res_taken ? res_target : res_pc + 32'd4;
            mis_cnt_d     = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b01;
                tgt_q[i] <= '0;
`ifdef BP_TAG_EN
                tag_q[i] <= '0;
`endif
            end
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mis_cnt_q        <= '0;
        end else begin
            valid_q          <= valid_d;
            cnt_q            <= cnt_d;
            tgt_q            <= tgt_d;
`ifdef BP_TAG_EN
            tag_q            <= tag_d;
`endif
            pred_valid_q     <= pred_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mis_cnt_q        <= mis_cnt_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_target      = pred_target_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with a direct-mapped branch target buffer (BTB), sitting at the fetch end of the core opposite the execute-stage branch comparator. It predicts direction and target for each fetched PC one cycle after lookup. It consumes the resolved outcome (taken/not-taken plus target) from execute to train its 2-bit counters. On a misprediction it issues a registered PC redirect.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of table entries; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 8, tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. Used only with BP_TAG_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  lookup request this cycle.
- fetch_pc  in  32  PC being fetched.
- pred_valid  out  1  registered; prediction for the previous cycle's fetch.
- pred_taken  out  1  predicted direction.
- pred_target  out  32  predicted next PC.
- res_valid  in  1  branch resolved this cycle.
- res_pc  in  32  PC of the resolved branch.
- res_taken  in  1  actual outcome (comparator result).
- res_target  in  32  computed branch target.
- res_pred_taken  in  1  direction that was predicted for this branch.
- res_pred_target  in  32  next PC that was predicted for this branch.
- redirect_valid  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  32  correct next PC.
- mispredict_count  out  32  running mispredict total.

## Operation
- Each entry holds: valid bit, 2-bit saturating counter, 32-bit target, and a tag (BP_TAG_EN only).
- Hit: valid=1 (and tag match if BP_TAG_EN).
- Lookup: pred_taken = hit & counter[1].
  - pred_target = stored target if pred_taken, else fetch_pc+4 (mod 2^32).
- Update on res_valid, at the index of res_pc:
  - Hit, res_taken=1: counter increments, saturating at 2'b11; target <= res_target.
  - Hit, res_taken=0: counter decrements, saturating at 2'b00; target unchanged.
  - Miss, res_taken=1: allocate/overwrite. valid=1, tag written, target=res_target, counter=2'b10.
  - Miss, res_taken=0: no change.
- Mispredict when either holds:
  - res_taken != res_pred_taken; or
  - res_taken=1 and res_target != res_pred_target.
- On mispredict: redirect_pc = res_taken ? res_target : res_pc+4.
  - mispredict_count increments and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values:
  - All valid bits 0; counters 2'b01.
  - pred_valid=0, pred_taken=0, pred_target=0.
  - redirect_valid=0, redirect_pc=0, mispredict_count=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first lookup after deassertion predicts not-taken.
- Lookup latency: 1 cycle. fetch at edge N produces pred_* valid after edge N+1.
  - pred_valid = registered fetch_valid & ~redirect_valid. A fetch in the cycle a redirect is being issued yields pred_valid=0.
  - When pred_valid=0, pred_taken and pred_target hold their previous values.
- Redirect latency: 1 cycle after res_valid. redirect_valid is high for exactly one cycle per mispredicted resolution; back-to-back resolutions give back-to-back pulses.
- Table update is written at the edge ending the res_valid cycle.
- Simultaneous lookup and update of the same index: the lookup sees pre-update contents (read-before-write).

## Configuration
- BP_TAG_EN defined: tags are stored and compared. A hit requires valid and tag equality; a taken miss overwrites the tag.
- BP_TAG_EN undefined: no tag storage; a hit requires valid only, so aliasing PCs share an entry. TAG_BITS is ignored.

## Test plan
- Reset, then fetch 0x100 -> pred_valid=1 next cycle, pred_taken=0, pred_target=0x104.
- Resolve 0x100 taken to 0x80 with res_pred_taken=0 -> redirect_valid pulse, redirect_pc=0x80, count=1. Refetch 0x100 -> pred_taken=1, pred_target=0x80.
- Train 0x100 taken ×3 (counter 11), then not-taken once -> still predicts taken. Second not-taken -> predicts 0x104.
- Same-cycle fetch and resolve of 0x200 (first taken) -> that fetch predicts not-taken; the next fetch predicts taken.
- Aliasing 0x100 vs 0x100+(4<<INDEX_BITS) -> with BP_TAG_EN the alias predicts not-taken; without it the alias predicts taken to 0x80.
- Assert rst_n low mid-stream with redirect pending -> all outputs 0 immediately; the trained PC predicts not-taken after release.
